// File: rtl/motor_pwm_gen.sv
// Fixed-period PWM generator driven by a signed duty command over valid/ready.
// Direction reversals coast with p low for DEAD_CYCLES before the sign flips.
module motor_pwm_gen #(
    parameter int unsigned PERIOD      = 1000,
    parameter int unsigned DUTY_W      = 12,
    parameter int unsigned DEAD_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DUTY_W-1:0] cmd_duty,
    output logic              p,
    output logic              sign,
    output logic              period_start,
    output logic              reversing
);

    localparam int unsigned CW = 16;
    localparam int unsigned TW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES + 1) : 1;

    typedef enum logic {
        StRun,
        StCoast
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CW-1:0]     mag_q, mag_d;
    logic [CW-1:0]     rev_mag_q, rev_mag_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [DUTY_W-1:0] hold_q, hold_d;
    logic              sign_d;
    logic              ready_d;

    // Magnitude of the held command; one extra bit so -2^(DUTY_W-1) cannot overflow.
    logic [DUTY_W:0]   duty_ext;
    logic [DUTY_W:0]   abs_duty;
    logic [CW-1:0]     new_mag;
    logic              new_dir;
    logic              hold_zero;
    logic              wrap;
    logic              accept;

    always_comb begin
        duty_ext  = {hold_q[DUTY_W-1], hold_q};
        abs_duty  = hold_q[DUTY_W-1] ? (~duty_ext + 1'b1) : duty_ext;
        new_dir   = hold_q[DUTY_W-1];
        hold_zero = (hold_q == '0);
        if (32'(abs_duty) > PERIOD) begin
            new_mag = CW'(PERIOD);
        end else begin
            new_mag = CW'(abs_duty);
        end
    end

    assign wrap   = (state_q == StRun) && (cnt_q == CW'(PERIOD - 1));
    assign accept = cmd_valid && cmd_ready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mag_d     = mag_q;
        rev_mag_d = rev_mag_q;
        timer_d   = timer_q;
        hold_d    = hold_q;
        sign_d    = sign;
        ready_d   = cmd_ready;

        unique case (state_q)
            StRun: begin
                if (wrap) begin
                    cnt_d = '0;
                    if (!cmd_ready) begin
                        ready_d = 1'b1;
                        if (hold_zero) begin
                            mag_d = '0;
                        end else if (new_dir == sign) begin
                            mag_d = new_mag;
                        end else begin
                            state_d   = StCoast;
                            timer_d   = '0;
                            rev_mag_d = new_mag;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StCoast: begin
                // cnt stays 0 throughout the coast; the new direction is always the opposite one.
                if (timer_q == TW'(DEAD_CYCLES - 1)) begin
                    state_d = StRun;
                    cnt_d   = '0;
                    sign_d  = ~sign;
                    mag_d   = rev_mag_q;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = StRun;
        endcase

        if (accept) begin
            ready_d = 1'b0;
            hold_d  = cmd_duty;
        end
    end

    // Outputs are registered from the next-state values so they line up with cnt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StRun;
            cnt_q        <= '0;
            mag_q        <= '0;
            rev_mag_q    <= '0;
            timer_q      <= '0;
            hold_q       <= '0;
            sign         <= 1'b0;
            cmd_ready    <= 1'b1;
            p            <= 1'b0;
            period_start <= 1'b0;
            reversing    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mag_q        <= mag_d;
            rev_mag_q    <= rev_mag_d;
            timer_q      <= timer_d;
            hold_q       <= hold_d;
            sign         <= sign_d;
            cmd_ready    <= ready_d;
            p            <= (state_d == StRun) && enable && (cnt_d < mag_d);
            period_start <= (state_d == StRun) && (cnt_d == '0);
            reversing    <= (state_d == StCoast);
        end
    end

endmodule

// File: tb/tb_motor_pwm_gen.sv
// Bench for motor_pwm_gen: integer reference model pushes expected outputs per cycle,
// a monitor pops and compares them against the DUT.
module tb_motor_pwm_gen;

    localparam int PERIOD = 1000;
    localparam int DUTY_W = 12;
    localparam int DEAD   = 64;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              enable;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [DUTY_W-1:0] cmd_duty;
    logic              p;
    logic              sign;
    logic              period_start;
    logic              reversing;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [4:0] exp_q[$];

    // Reference model state: plain integers describing position, coast time left, queue.
    int m_pos, m_coast, m_mag, m_rev_mag, m_hold;
    bit m_sign, m_full;

    motor_pwm_gen #(
        .PERIOD      (PERIOD),
        .DUTY_W      (DUTY_W),
        .DEAD_CYCLES (DEAD)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_duty     (cmd_duty),
        .p            (p),
        .sign         (sign),
        .period_start (period_start),
        .reversing    (reversing)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [4:0] got, input logic [4:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s cycle %0d: {p,sign,ps,rev,ready} got %b want %b",
                     name, cyc, got, want);
            if (n_bad >= 50) begin
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
                $finish;
            end
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s cycle %0d: wait expired, got no event want event", name, cyc);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pos = 0; m_coast = 0; m_mag = 0; m_rev_mag = 0; m_hold = 0;
            m_sign = 0; m_full = 0;
            exp_q.delete();
        end else begin
            bit acc;
            cyc++;
            acc = cmd_valid && !m_full;
            if (m_coast > 0) begin
                if (m_coast == 1) begin
                    m_coast = 0;
                    m_pos   = 0;
                    m_sign  = !m_sign;
                    m_mag   = m_rev_mag;
                end else begin
                    m_coast--;
                end
            end else if (m_pos == PERIOD - 1) begin
                m_pos = 0;
                if (m_full) begin
                    m_full = 0;
                    if (m_hold == 0) begin
                        m_mag = 0;
                    end else begin
                        bit nd;
                        int nm;
                        nd = (m_hold < 0);
                        nm = nd ? -m_hold : m_hold;
                        if (nm > PERIOD) nm = PERIOD;
                        if (nd == m_sign) begin
                            m_mag = nm;
                        end else begin
                            m_coast   = DEAD;
                            m_rev_mag = nm;
                        end
                    end
                end
            end else begin
                m_pos++;
            end
            if (acc) begin
                m_full = 1;
                m_hold = int'($signed(cmd_duty));
            end
            exp_q.push_back({(m_coast == 0) && enable && (m_pos < m_mag), m_sign,
                             (m_coast == 0) && (m_pos == 0), m_coast > 0, !m_full});
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset_hold", {p, sign, period_start, reversing, cmd_ready}, 5'b00001);
        end else if (exp_q.size() > 0) begin
            logic [4:0] e;
            e = exp_q.pop_front();
            check("cycle", {p, sign, period_start, reversing, cmd_ready}, e);
        end
    end

    // Called at a negedge; returns at the negedge after the accepting posedge, valid still high.
    task automatic send(input int d);
        int w;
        w = 0;
        cmd_duty  = DUTY_W'(d);
        cmd_valid = 1'b1;
        while (!cmd_ready && w < 5000) begin
            @(negedge clk);
            w++;
        end
        if (!cmd_ready) timeout("send_ready");
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        cmd_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        bit seen;
        rst_n     = 1'b0;
        enable    = 1'b1;
        cmd_valid = 1'b0;
        cmd_duty  = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(5);

        send(250);            idle(2500);
        send(-400);           idle(2500);
        send(2047);           idle(2200);
        send(-2048);          idle(2300);
        send(300); send(500); idle(3000);

        // Drop enable during a high phase.
        seen = 0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge clk);
            seen = p;
        end
        if (!seen) timeout("wait_p_high");
        repeat (20) @(negedge clk);
        enable = 1'b0;
        repeat (100) @(negedge clk);
        enable = 1'b1;
        idle(1500);

        // Reversal, refill the holding register during the coast, then reset mid-coast.
        send(-100);
        cmd_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge clk);
            seen = reversing;
        end
        if (!seen) timeout("wait_coast");
        repeat (4) @(negedge clk);
        send(200);
        cmd_valid = 1'b0;
        repeat (24) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_reset", {p, sign, period_start, reversing, cmd_ready}, 5'b00001);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(2000);

        for (int k = 0; k < 12; k++) begin
            int d;
            d = ($urandom_range(0, 4) == 0) ? 0 : int'($signed(DUTY_W'($urandom_range(0, 4095))));
            enable = ($urandom_range(0, 5) != 0);
            send(d);
            idle($urandom_range(200, 1800));
        end
        enable = 1'b1;
        idle(1200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
